// File: rtl/holdreg_rr_arbiter_pkg.sv
// Shared definitions for the round-robin holding-register arbiter.
//   - arb_state_e    : holding-register occupancy (EMPTY / FULL)
//   - DEFAULT_N_REQ  : default number of requesters
//   - DEFAULT_WIDTH  : default data word width
package holdreg_rr_arbiter_pkg;

  localparam int DEFAULT_N_REQ = 4;
  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/holdreg_rr_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational rotating-priority search.
// Starting just after the last winner, returns the first active requester.
// Ports:
//   req      in  N_REQ  request vector
//   last     in  PTR_W  index of the previous winner
//   pick     out N_REQ  one-hot winner (all zero when no request)
//   pick_idx out PTR_W  winner index (zero when no request)
//   any      out 1      at least one request is active
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] last,
  output logic [N_REQ-1:0] pick,
  output logic [PTR_W-1:0] pick_idx,
  output logic             any
);

  int idx;

  // NOTE: every output of this block is given a default before the loop, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    idx      = 0;
    // Offset 1..N_REQ visits last+1 first and last itself at the very end,
    // so the previous winner has the lowest priority.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!any && req[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/holdreg_rr_arbiter.sv
// holdreg_rr_arbiter: round-robin arbiter sharing one holding register among
// N_REQ requesters, with a VALID/READY handshake downstream and a flush.
// Ports:
//   clock       in  1            rising-edge clock
//   reset_n     in  1            synchronous reset, active-low
//   req         in  N_REQ        per-requester level request
//   din         in  N_REQ*WIDTH  requester words, slice i = din[i*WIDTH +: WIDTH]
//   flush       in  1            synchronous clear of the held word
//   gnt         out N_REQ        one-hot grant, same cycle as capture
//   dout        out WIDTH        held word
//   dout_valid  out 1            held word valid
//   dout_ready  in  1            downstream accepts dout this cycle
//   dout_src    out PTR_W        requester index that supplied dout
//   busy        out 1            dout_valid | (|req)
module holdreg_rr_arbiter
  import holdreg_rr_arbiter_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int PTR_W = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din,
  input  logic                   flush,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [PTR_W-1:0]       dout_src,
  output logic                   busy
);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] last_q;
  logic [WIDTH-1:0] dout_q;
  logic [PTR_W-1:0] src_q;

  logic [N_REQ-1:0] pick;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             free;
  logic             grant_en;
  logic [WIDTH-1:0] win_word;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req      (req),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  // The register can take a new word when empty, or when the current word
  // leaves this cycle; that is what sustains one word per cycle.
  assign free     = (state_q == ST_EMPTY) || dout_ready;
  // reset_n is folded in so no grant is ever shown during a reset cycle.
  assign grant_en = reset_n && !flush && free && pick_any;
  assign gnt      = grant_en ? pick : '0;
  assign win_word = din[int'(pick_idx)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (grant_en) begin
      state_d = ST_FULL;
    end else if (state_q == ST_FULL && dout_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the data register is reset along with the control state because
  // dout must read zero after reset and flush, not just be marked invalid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dout_q <= '0;
      src_q  <= '0;
      last_q <= PTR_W'(N_REQ - 1);
    end else if (flush) begin
      dout_q <= '0;
    end else if (grant_en) begin
      dout_q <= win_word;
      src_q  <= pick_idx;
      last_q <= pick_idx;
    end
  end

  assign dout       = dout_q;
  assign dout_src   = src_q;
  assign dout_valid = (state_q == ST_FULL);
  assign busy       = dout_valid || (|req);

endmodule

// File: tb/tb_holdreg_rr_arbiter.sv
module tb_holdreg_rr_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int PTR_W = 2;

  typedef struct packed {
    logic [PTR_W-1:0] src;
    logic [WIDTH-1:0] word;
  } sb_entry_t;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] din;
  logic                   flush;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic [PTR_W-1:0]       dout_src;
  logic                   busy;

  int n_cmp = 0;
  int n_err = 0;

  sb_entry_t  sb_q[$];
  int         model_last = N_REQ - 1;
  logic [N_REQ-1:0] exp_g;
  int         exp_idx;

  always #5 clock = ~clock;

  holdreg_rr_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH),
    .PTR_W (PTR_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .din        (din),
    .flush      (flush),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_src   (dout_src),
    .busy       (busy)
  );

  // Reference arbitration: rotating search from model_last+1.
  function automatic int model_pick();
    if (!reset_n || flush) return -1;
    if (!(sb_q.size() == 0 || dout_ready)) return -1;
    for (int k = 1; k <= N_REQ; k++) begin
      int i;
      i = (model_last + k) % N_REQ;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  // Scoreboard monitor: checks outputs mid-cycle, advances the model at the edge.
  task automatic run_monitor();
    forever begin
      @(negedge clock);
      exp_idx = model_pick();
      exp_g   = (exp_idx >= 0) ? (N_REQ'(1) << exp_idx) : '0;
      n_cmp++;
      if (gnt !== exp_g) begin
        n_err++;
        $display("FAIL sb_gnt t=%0t: got %b expected %b", $time, gnt, exp_g);
      end
      n_cmp++;
      if (dout_valid !== (sb_q.size() != 0)) begin
        n_err++;
        $display("FAIL sb_valid t=%0t: got %b expected %b", $time, dout_valid, sb_q.size() != 0);
      end
      if (sb_q.size() != 0) begin
        n_cmp++;
        if (dout !== sb_q[0].word || dout_src !== sb_q[0].src) begin
          n_err++;
          $display("FAIL sb_data t=%0t: got %h/src %0d expected %h/src %0d",
                   $time, dout, dout_src, sb_q[0].word, sb_q[0].src);
        end
      end
      n_cmp++;
      if (busy !== ((sb_q.size() != 0) || (|req))) begin
        n_err++;
        $display("FAIL sb_busy t=%0t: got %b", $time, busy);
      end
      @(posedge clock);
      if (!reset_n) begin
        sb_q.delete();
        model_last = N_REQ - 1;
      end else if (flush) begin
        sb_q.delete();
      end else begin
        if (sb_q.size() != 0 && dout_ready) void'(sb_q.pop_front());
        if (exp_idx >= 0) begin
          sb_q.push_back({PTR_W'(exp_idx), din[exp_idx*WIDTH +: WIDTH]});
          model_last = exp_idx;
        end
      end
    end
  endtask

  task automatic expect_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    req        = 4'hF;
    flush      = 1'b0;
    dout_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) din[i*WIDTH +: WIDTH] = 32'hA0 + i;
    repeat (2) begin
      @(negedge clock); #1;
      if (gnt !== 4'h0) begin n_err++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
      if (dout !== 32'h0) begin n_err++; $display("FAIL reset_dout: got %h expected 0", dout); end
      n_cmp += 3;
    end
    @(posedge clock); #1;
    reset_n    = 1'b1;
    dout_ready = 1'b1;
    @(negedge clock); #1;
    n_cmp++;
    if (gnt !== 4'b0001) begin n_err++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
  endtask

  task automatic test_fairness();
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock); #1;
      @(negedge clock); #1;
      n_cmp++;
      if (gnt !== (4'b0001 << (k % 4))) begin
        n_err++;
        $display("FAIL fair_gnt[%0d]: got %b expected %b", k, gnt, 4'b0001 << (k % 4));
      end
      n_cmp++;
      if (dout !== 32'hA0 + ((k - 1) % 4) || dout_valid !== 1'b1) begin
        n_err++;
        $display("FAIL fair_dout[%0d]: got %h v=%b expected %h", k, dout, dout_valid, 32'hA0 + ((k - 1) % 4));
      end
    end
  endtask

  task automatic test_back_pressure();
    @(posedge clock); #1;
    @(posedge clock); #1;
    dout_ready = 1'b0;
    req        = 4'hC;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock); #1;
      n_cmp++;
      if (dout !== 32'hA1 || gnt !== 4'h0 || dout_valid !== 1'b1 || dout_src !== 2'd1) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got dout %h gnt %b v %b src %0d expected A1 0000 1 1",
                 j, dout, gnt, dout_valid, dout_src);
      end
      @(posedge clock); #1;
    end
    dout_ready = 1'b1;
    @(negedge clock); #1;
    expect_val("bp_release_gnt", 64'(gnt), 64'h4);
    @(posedge clock); #1;
    req = 4'h0;
    @(negedge clock); #1;
    expect_val("bp_next_dout", 64'(dout), 64'hA2);
  endtask

  task automatic test_wrap_skip();
    @(posedge clock); #1;
    req = 4'b0011;
    @(negedge clock); #1;
    expect_val("wrap_gnt", 64'(gnt), 64'b0001);
    @(posedge clock); #1;
    req = 4'b0010;
    @(negedge clock); #1;
    expect_val("skip_gnt", 64'(gnt), 64'b0010);
  endtask

  task automatic test_flush();
    @(posedge clock); #1;
    req   = 4'b0001;
    flush = 1'b1;
    @(negedge clock); #1;
    expect_val("flush_gnt", 64'(gnt), 64'h0);
    @(posedge clock); #1;
    flush = 1'b0;
    req   = 4'h0;
    @(negedge clock); #1;
    expect_val("flush_valid", 64'(dout_valid), 64'h0);
    expect_val("flush_dout", 64'(dout), 64'h0);
    @(posedge clock); #1;
    req = 4'b0011;
    @(negedge clock); #1;
    expect_val("flush_last_kept", 64'(gnt), 64'b0001);
  endtask

  task automatic test_midop_reset();
    @(posedge clock); #1;
    req     = 4'b0010;
    reset_n = 1'b0;
    @(negedge clock); #1;
    expect_val("midrst_gnt", 64'(gnt), 64'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    req     = 4'b1001;
    @(negedge clock); #1;
    expect_val("midrst_valid", 64'(dout_valid), 64'h0);
    expect_val("midrst_dout", 64'(dout), 64'h0);
    expect_val("midrst_last3", 64'(gnt), 64'b0001);
    @(posedge clock); #1;
    req = 4'h0;
    @(negedge clock); #1;
    expect_val("midrst_capture", 64'(dout), 64'hA0);
    @(posedge clock); #1;
    @(negedge clock); #1;
    expect_val("ready_while_empty", 64'(dout_valid), 64'h0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(posedge clock); #1;
      req        = N_REQ'($urandom);
      dout_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N_REQ; i++) din[i*WIDTH +: WIDTH] = $urandom;
    end
    @(posedge clock); #1;
    req   = 4'h0;
    flush = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    req        = '0;
    din        = '0;
    flush      = 1'b0;
    dout_ready = 1'b0;
    fork
      run_monitor();
    join_none
    test_reset();
    test_fairness();
    test_back_pressure();
    test_wrap_skip();
    test_flush();
    test_midop_reset();
    test_random();
    repeat (3) @(posedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
